// File: rtl/register_array_write.sv
// ----------------------------------------------------------------------------
// register_array_write
// Write side of the 64-bit ARM register file: the 32 architectural registers
// X0..X31 held as flip-flop banks, written through a 5:32 one-hot decoder.
// X31 is the zero register (XZR): it has no storage, always reads 0 and
// silently drops writes.
//
// Ports
//   clk            in   single clock, all updates on the rising edge
//   reset          in   synchronous active-high clear of X0..X30
//   RegWrite       in   write enable for this cycle
//   WriteRegister  in   destination register index (5 bits)
//   WriteData      in   value to store (64 bits)
//   RegisterData   out  packed contents of all registers, RegisterData[i] = Xi
// ----------------------------------------------------------------------------
module register_array_write #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ZERO_REG   = 31,
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 RegWrite,
    input  logic [ADDR_WIDTH-1:0]                WriteRegister,
    input  logic [DATA_WIDTH-1:0]                WriteData,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] RegisterData
);

    // One-hot write decoder, gated by RegWrite. With RegWrite low every
    // enable is forced to 0 regardless of an unknown WriteRegister.
    logic [NUM_REGS-1:0] w_enable;

    always_comb begin
        w_enable = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_enable[i] = RegWrite && (WriteRegister == ADDR_WIDTH'(i));
        end
    end

    // At most one bank may be enabled in any cycle.
    always_comb begin
        assert ($onehot0(w_enable));
    end

    // Register banks. The zero register gets no flops: its decoded enable is
    // simply left unconnected, so a write to it cannot land anywhere.
    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_bank
        if (g == int'(ZERO_REG)) begin : g_zero
            assign RegisterData[g] = '0;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_q;

            // Reset wins over a same-cycle write; otherwise hold unless enabled.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q <= '0;
                end else if (w_enable[g]) begin
                    r_q <= WriteData;
                end
            end

            assign RegisterData[g] = r_q;
        end
    end

endmodule

// File: tb/tb_register_array_write.sv
module tb_register_array_write;

    localparam int unsigned DW = 64;
    localparam int unsigned NR = 32;
    localparam int unsigned ZR = 31;

    logic                         clk;
    logic                         reset;
    logic                         RegWrite;
    logic [4:0]                   WriteRegister;
    logic [DW-1:0]                WriteData;
    logic [NR-1:0][DW-1:0]        RegisterData;

    register_array_write dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegisterData  (RegisterData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: what each Xi must hold after the most recent edge.
    logic [DW-1:0] model [NR];
    bit            checking = 1'b0;
    int            n_tests  = 0;
    int            n_fail   = 0;

    // Compare every register against the model on every falling edge once the
    // first reset has been applied. Inputs for the next edge are already
    // driven here, so this also checks there is no write-to-read bypass.
    always @(negedge clk) begin
        if (checking) begin
            for (int r = 0; r < int'(NR); r++) begin
                n_tests++;
                if (RegisterData[r] !== model[r]) begin
                    n_fail++;
                    $display("FAIL model_X%0d t=%0t got=%h exp=%h", r, $time, RegisterData[r], model[r]);
                end
            end
        end
    end

    // Literal expectation pinning the model and the DUT to hand-computed values.
    task automatic check_lit(input string name, input int r, input logic [DW-1:0] exp);
        n_tests++;
        if (RegisterData[r] !== exp || model[r] !== exp) begin
            n_fail++;
            $display("FAIL %s X%0d dut=%h model=%h exp=%h", name, r, RegisterData[r], model[r], exp);
        end
    endtask

    // Drive one cycle: inputs set away from the edge, model updated after it.
    task automatic step(input logic rst, input logic we, input logic [4:0] addr,
                        input logic [DW-1:0] data);
        reset         = rst;
        RegWrite      = we;
        WriteRegister = addr;
        WriteData     = data;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int r = 0; r < int'(NR); r++) model[r] = '0;
        end else if (we && int'(addr) != int'(ZR)) begin
            model[addr] = data;
        end
        model[ZR] = '0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom});
    endtask

    initial begin
        for (int r = 0; r < int'(NR); r++) model[r] = '0;
        reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        #2;

        // Reset then idle with random inputs.
        step(1'b1, 1'b0, 5'd0, '0);
        checking = 1'b1;
        check_lit("reset_x0", 0, 64'h0);
        check_lit("reset_x30", 30, 64'h0);
        for (int k = 0; k < 5; k++) idle();
        check_lit("idle_x17", 17, 64'h0);

        // Walk all registers, then attempt a write to XZR.
        for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 5'(i), 64'hA5A5_0000_0000_0000 + 64'(i));
        step(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        check_lit("walk_x0", 0, 64'hA5A5_0000_0000_0000);
        check_lit("walk_x30", 30, 64'hA5A5_0000_0000_001E);
        check_lit("walk_xzr", 31, 64'h0);

        // Enable gating on X5.
        step(1'b0, 1'b1, 5'd5, 64'h1234);
        step(1'b0, 1'b0, 5'd5, 64'hDEAD_BEEF);
        check_lit("gate_hold", 5, 64'h1234);
        step(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF);
        check_lit("gate_write", 5, 64'hDEAD_BEEF);
        check_lit("gate_x4", 4, 64'hA5A5_0000_0000_0004);

        // Back-to-back writes to X7.
        step(1'b0, 1'b1, 5'd7, 64'h1);
        check_lit("b2b_1", 7, 64'h1);
        step(1'b0, 1'b1, 5'd7, 64'h2);
        check_lit("b2b_2", 7, 64'h2);
        step(1'b0, 1'b1, 5'd7, 64'h3);
        check_lit("b2b_3", 7, 64'h3);
        check_lit("b2b_x6", 6, 64'hA5A5_0000_0000_0006);
        check_lit("b2b_x8", 8, 64'hA5A5_0000_0000_0008);

        // Reset priority over a same-cycle write.
        for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 5'(i), {$urandom, $urandom} | 64'h1);
        step(1'b1, 1'b1, 5'd3, 64'h55);
        check_lit("rstprio_x3", 3, 64'h0);
        check_lit("rstprio_x12", 12, 64'h0);
        step(1'b0, 1'b1, 5'd3, 64'h55);
        check_lit("post_rst_x3", 3, 64'h55);

        // Read during write: old value visible until the edge.
        step(1'b0, 1'b1, 5'd10, 64'h10);
        reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 64'h20;
        @(negedge clk);
        check_lit("rdw_old", 10, 64'h10);
        step(1'b0, 1'b1, 5'd10, 64'h20);
        check_lit("rdw_new", 10, 64'h20);

        // Randomized traffic with occasional resets and XZR writes.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 31)), {$urandom, $urandom});
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_array_write.md
Name: register_array_write

Overview:
- Write side of the 64-bit ARM register file. It holds the 32 architectural registers X0..X31 as 64-bit flip-flop banks.
- A 5:32 write decoder with enable drives the bank enables. All register contents are exported as one packed 32x64 bus, which feeds the read-port 64x32:1 multiplexers.
- X31 is the zero register (XZR): it always reads 0 and ignores writes.

Parameters:
- DATA_WIDTH, 64, width of each register and of WriteData.
- NUM_REGS, 32, number of architectural registers. Fixed at 32 because the address is 5 bits.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  write enable for this cycle.
- WriteRegister  input  5  destination register index.
- WriteData  input  64  value to store.
- RegisterData  output  [31:0][63:0]  packed contents of all registers. RegisterData[i] is Xi. This bus drives the read-port muxes directly.

Behaviour:
- Interface decisions: one clock, clk. Reset is synchronous and active-high, port reset. No asynchronous set or clear anywhere.
- Reset:
  - When reset=1 at a rising clk edge, every register X0..X30 becomes 64'h0.
  - reset takes priority over RegWrite in the same cycle; the write is discarded.
  - Reset asserted mid-sequence clears all state on that edge. Writes resume on the first edge with reset=0.
- Post-reset outputs: RegisterData is all zeros from the edge after reset until the first write.
- Decoder:
  - Combinational 5:32 one-hot decoder, gated by RegWrite.
  - Enable[i] = RegWrite && (WriteRegister == i).
  - At most one bank enable is high in any cycle.
  - RegWrite=0 gives all enables low and no state change.
- Storage:
  - Each of X0..X30 is a 64-bit register built from D flip-flops with a per-bank enable (hold-mux on D).
  - On a rising edge with Enable[i]=1 and reset=0, Xi <= WriteData. Otherwise Xi holds its value.
- Zero register:
  - RegisterData[31] is tied to 64'h0; no flip-flops are instantiated for it.
  - A write with WriteRegister=5'd31 has no effect anywhere.
  - A write to index 31 must not alias to any other register.
- Latency:
  - A write issued in cycle N is visible on RegisterData from cycle N+1 (after the edge).
  - No internal write-to-read bypass. A read in cycle N of the register being written returns the old value. Forwarding is the pipeline's job.
- Outputs are registered state only. No combinational path from WriteData or RegWrite to RegisterData.
- Back-to-back writes to the same register in consecutive cycles: each edge takes the newest WriteData; no loss or reordering.
- X/Z handling:
  - If RegWrite=0, WriteRegister and WriteData may be X without corrupting state.
  - If RegWrite=1, WriteRegister is required to be known.
- Gate delays follow the team's standard timescale (1ns/10ps) and per-gate delay model, so the decoder must settle within one clock period at the target frequency.

Test Plan:
- Reset then idle: reset=1 for 1 cycle, then RegWrite=0 for 5 cycles with random WriteRegister/WriteData -> RegisterData[0..31] all 64'h0 throughout.
- Walk all registers: for i=0..30 write WriteData=64'hA5A5_0000_0000_0000+i to WriteRegister=i, then write 64'hFFFF_FFFF_FFFF_FFFF to WriteRegister=31 -> RegisterData[i] equals its written value; RegisterData[31]=0; each value appears exactly one cycle after its write edge.
- Enable gating: with X5=64'h1234, drive RegWrite=0, WriteRegister=5, WriteData=64'hDEAD_BEEF -> X5 stays 64'h1234. Set RegWrite=1 -> X5=64'hDEAD_BEEF next cycle; all other registers unchanged.
- Back-to-back same target: write X7=64'h1, then 64'h2, then 64'h3 on consecutive edges -> RegisterData[7] reads 1, 2, 3 on successive cycles; X6 and X8 unchanged.
- Reset priority mid-operation: load X0..X30 with nonzero values, then assert reset=1 together with RegWrite=1, WriteRegister=3, WriteData=64'h55 -> after the edge all registers are 0, including X3. Deassert reset, write X3=64'h55 -> X3=64'h55 next cycle.
- Read-during-write: X10=64'h10, then write X10=64'h20 in cycle N -> RegisterData[10] is 64'h10 during cycle N and 64'h20 from cycle N+1.
